// File: rtl/pixel_buffer_if.sv
// Push/pop bus between the shader, the pixel FIFO and frame_buffer_handler.
// master drives requests and observes status; slave is the FIFO itself.
interface pixel_buffer_if #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned PIX_ID_W = 19,
  parameter int unsigned RGB_W    = 24
);
  localparam int unsigned DATA_W = PIX_ID_W + RGB_W;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

  logic                pb_we;
  logic [PIX_ID_W-1:0] pb_wr_id;
  logic [RGB_W-1:0]    pb_wr_rgb;
  logic                pb_full;
  logic                pb_re;
  logic                pb_empty;
  logic [DATA_W-1:0]   pb_data;
  logic [CNT_W-1:0]    pb_count;
  logic                pb_overflow;
  logic                pb_underflow;

  modport master (
    output pb_we, pb_wr_id, pb_wr_rgb, pb_re,
    input  pb_full, pb_empty, pb_data, pb_count, pb_overflow, pb_underflow
  );

  modport slave (
    input  pb_we, pb_wr_id, pb_wr_rgb, pb_re,
    output pb_full, pb_empty, pb_data, pb_count, pb_overflow, pb_underflow
  );
endinterface

// File: rtl/pixel_buffer.sv
// First-word-fall-through pixel FIFO with occupancy count and sticky
// overflow/underflow flags; sits between shader output and frame buffer handler.
module pixel_buffer #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned PIX_ID_W = 19,
  parameter int unsigned RGB_W    = 24
) (
  input  logic           clk,
  input  logic           rst_b,
  pixel_buffer_if.slave  pb
);
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned PW     = AW + 1;
  localparam int unsigned CNT_W  = AW + 1;
  localparam int unsigned DATA_W = PIX_ID_W + RGB_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_n;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_n;
  logic [CNT_W-1:0] count_q,  count_n;
  logic             full_q,   full_n;
  logic             empty_q,  empty_n;
  logic             ovf_q,    ovf_n;
  logic             udf_q,    udf_n;
  logic             push_c;
  logic             pop_c;

  // Acceptance uses the registered flags, so a full pop+push drops the push
  // and an empty push+pop drops the pop.
  always_comb begin
    push_c = pb.pb_we & ~full_q;
    pop_c  = pb.pb_re & ~empty_q;
  end

  // Next-state for pointers, count, flags.
  always_comb begin
    wr_ptr_n = wr_ptr_q;
    rd_ptr_n = rd_ptr_q;
    count_n  = count_q;
    ovf_n    = ovf_q;
    udf_n    = udf_q;

    if (push_c) wr_ptr_n = wr_ptr_q + PW'(1);
    if (pop_c)  rd_ptr_n = rd_ptr_q + PW'(1);

    case ({push_c, pop_c})
      2'b10:   count_n = count_q + CNT_W'(1);
      2'b01:   count_n = count_q - CNT_W'(1);
      default: count_n = count_q;
    endcase

    if (pb.pb_we & full_q)  ovf_n = 1'b1;
    if (pb.pb_re & empty_q) udf_n = 1'b1;

    // MSB is the wrap bit: equal pointers mean empty, same slot on opposite laps means full.
    empty_n = (wr_ptr_n == rd_ptr_n);
    full_n  = (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]) &&
              (wr_ptr_n[AW] != rd_ptr_n[AW]);
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_n;
      rd_ptr_q <= rd_ptr_n;
      count_q  <= count_n;
      full_q   <= full_n;
      empty_q  <= empty_n;
      ovf_q    <= ovf_n;
      udf_q    <= udf_n;
    end
  end

  // Storage is deliberately not reset; stale words are hidden behind pb_empty.
  always_ff @(posedge clk) begin
    if (rst_b && push_c) mem[wr_ptr_q[AW-1:0]] <= {pb.pb_wr_id, pb.pb_wr_rgb};
  end

  assign pb.pb_data      = mem[rd_ptr_q[AW-1:0]];
  assign pb.pb_full      = full_q;
  assign pb.pb_empty     = empty_q;
  assign pb.pb_count     = count_q;
  assign pb.pb_overflow  = ovf_q;
  assign pb.pb_underflow = udf_q;
endmodule

// File: tb/tb_pixel_buffer.sv
// Directed and randomised checks of pixel_buffer against hand-computed values
// and a queue reference model.
module tb_pixel_buffer;
  localparam int unsigned DEPTH    = 64;
  localparam int unsigned PIX_ID_W = 19;
  localparam int unsigned RGB_W    = 24;
  localparam int unsigned DATA_W   = PIX_ID_W + RGB_W;

  logic clk;
  logic rst_b;
  int   errors;
  int   checks;

  pixel_buffer_if #(.DEPTH(DEPTH), .PIX_ID_W(PIX_ID_W), .RGB_W(RGB_W)) bus ();

  pixel_buffer #(.DEPTH(DEPTH), .PIX_ID_W(PIX_ID_W), .RGB_W(RGB_W)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .pb    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [RGB_W-1:0] rgb_of(input int i);
    return RGB_W'(i * 7 + 24'h100003);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of requests, then sample 1ns after the edge.
  task automatic step(input logic we, input logic [PIX_ID_W-1:0] id,
                      input logic [RGB_W-1:0] rgb, input logic re);
    bus.pb_we     = we;
    bus.pb_wr_id  = id;
    bus.pb_wr_rgb = rgb;
    bus.pb_re     = re;
    @(posedge clk);
    #1;
    bus.pb_we = 1'b0;
    bus.pb_re = 1'b0;
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    step(1'b0, '0, '0, 1'b0);
    rst_b = 1'b1;
  endtask

  task automatic status(input string tag, input int cnt, input logic e,
                        input logic f, input logic ov, input logic un);
    check({tag, "_count"}, 64'(bus.pb_count), 64'(cnt));
    check({tag, "_empty"}, 64'(bus.pb_empty), 64'(e));
    check({tag, "_full"},  64'(bus.pb_full),  64'(f));
    check({tag, "_ovf"},   64'(bus.pb_overflow), 64'(ov));
    check({tag, "_udf"},   64'(bus.pb_underflow), 64'(un));
  endtask

  logic [DATA_W-1:0]   q [$];
  logic [DATA_W-1:0]   exp_word;
  logic                r_we, r_re, e_push, e_pop, m_ov, m_un;
  logic [PIX_ID_W-1:0] r_id;
  logic [RGB_W-1:0]    r_rgb;

  initial begin
    errors = 0;
    checks = 0;
    rst_b = 1'b0;
    bus.pb_we = 1'b0;
    bus.pb_re = 1'b0;
    bus.pb_wr_id = '0;
    bus.pb_wr_rgb = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    status("reset", 0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Single push becomes head next cycle, pop empties again.
    step(1'b1, 19'd5, 24'hFF0000, 1'b0);
    status("t1_push", 1, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_word = {19'd5, 24'hFF0000};
    check("t1_data", 64'(bus.pb_data), 64'(exp_word));
    step(1'b0, '0, '0, 1'b1);
    status("t1_pop", 0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Fill to full, overflow push ignored, drain in order.
    for (int i = 0; i < 64; i++) step(1'b1, PIX_ID_W'(i), rgb_of(i), 1'b0);
    status("t2_full", 64, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 19'd99, 24'h123456, 1'b0);
    status("t2_ovf", 64, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 64; i++) begin
      exp_word = {PIX_ID_W'(i), rgb_of(i)};
      check("t2_drain_data", 64'(bus.pb_data), 64'(exp_word));
      step(1'b0, '0, '0, 1'b1);
    end
    status("t2_drained", 0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Push+pop at full: pop wins, push dropped.
    do_reset();
    for (int i = 0; i < 64; i++) step(1'b1, PIX_ID_W'(i), rgb_of(i), 1'b0);
    step(1'b1, 19'd77, 24'h777777, 1'b1);
    status("t3_both_full", 63, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_word = {19'd1, rgb_of(1)};
    check("t3_head", 64'(bus.pb_data), 64'(exp_word));
    for (int i = 1; i < 64; i++) step(1'b0, '0, '0, 1'b1);
    status("t3_drained", 0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Pop at empty, then push+pop at empty.
    do_reset();
    step(1'b0, '0, '0, 1'b1);
    status("t4_pop_empty", 0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 19'd42, 24'h0A0B0C, 1'b0);
    exp_word = {19'd42, 24'h0A0B0C};
    check("t4_ptr_data", 64'(bus.pb_data), 64'(exp_word));
    step(1'b0, '0, '0, 1'b1);
    do_reset();
    step(1'b1, 19'd33, 24'h00FF00, 1'b1);
    status("t4_both_empty", 1, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_word = {19'd33, 24'h00FF00};
    check("t4_data", 64'(bus.pb_data), 64'(exp_word));
    step(1'b0, '0, '0, 1'b1);
    status("t4_pop", 0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Random traffic against a queue model; pointers wrap many times.
    do_reset();
    q.delete();
    m_ov = 1'b0;
    m_un = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      r_we  = 1'($urandom_range(0, 1));
      r_re  = 1'($urandom_range(0, 1));
      r_id  = PIX_ID_W'($urandom);
      r_rgb = RGB_W'($urandom);
      e_push = r_we && (q.size() < DEPTH);
      e_pop  = r_re && (q.size() > 0);
      if (r_we && q.size() == DEPTH) m_ov = 1'b1;
      if (r_re && q.size() == 0)     m_un = 1'b1;
      if (e_pop) check("rnd_data", 64'(bus.pb_data), 64'(q[0]));
      step(r_we, r_id, r_rgb, r_re);
      if (e_pop)  void'(q.pop_front());
      if (e_push) q.push_back({r_id, r_rgb});
      status("rnd", q.size(), q.size() == 0, q.size() == DEPTH, m_ov, m_un);
    end

    // Mid-stream reset discards 10 stored entries and clears sticky flags.
    do_reset();
    step(1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, PIX_ID_W'(200 + i), rgb_of(i), 1'b0);
    status("t6_pre", 10, 1'b0, 1'b0, 1'b0, 1'b1);
    do_reset();
    status("t6_reset", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 19'd500, 24'hABCDEF, 1'b0);
    exp_word = {19'd500, 24'hABCDEF};
    check("t6_new_data", 64'(bus.pb_data), 64'(exp_word));
    step(1'b0, '0, '0, 1'b1);
    status("t6_pop", 0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
